// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   arb_state_t : arbiter FSM states
//   TAG_PREFIX  : upper nibble of the channel tag byte (tag build only)
//   FRAME_CNT_W : width of the completed-frame counter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam logic [3:0]  TAG_PREFIX  = 4'hA;
  localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from rr_ptr,
// wrapping modulo N_CH. Purely combinational.
//   req       in  N_CH          request vector
//   rr_ptr    in  $clog2(N_CH)  search start index (must be < N_CH)
//   winner    out $clog2(N_CH)  selected index (0 when none valid)
//   any_valid out 1             at least one request bit set
module uart_rr_pick #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] rr_ptr,
  output logic [$clog2(N_CH)-1:0] winner,
  output logic                    any_valid
);

  localparam int unsigned IDX_W = $clog2(N_CH);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // rr_ptr + k < 2*N_CH, so a single conditional subtract performs the wrap
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_CH)) sum = sum - (IDX_W+1)'(N_CH);
      idx = IDX_W'(sum);
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_CH requesters.
// Accepts one byte from the winner, pulses tx_start with stable tx_data, then
// follows tx_busy through the frame before re-arbitrating. A start that never
// raises tx_busy within WAIT_CYC cycles is dropped with an err_timeout pulse.
// Optional macro UART_ARB_TAG_EN: each accepted byte is preceded by a tag
// frame 0xA0 | grant_id; frame_cnt counts data frames only.
//   clk, reset   in  clock, synchronous active-high reset
//   req_valid    in  N_CH    per-channel byte available
//   req_data     in  8*N_CH  channel i byte at [8i+7:8i]
//   req_ready    out N_CH    one-hot accept (combinational, IDLE only)
//   tx_start     out 1       single-cycle transmitter start
//   tx_data      out 8       byte to transmitter
//   tx_busy      in  1       transmitter busy
//   grant_id     out         channel being served
//   active       out 1       FSM not in IDLE
//   err_timeout  out 1       one-cycle timeout pulse
//   frame_cnt    out 16      completed data frames (wrapping)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned WAIT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req_valid,
  input  logic [8*N_CH-1:0]       req_data,
  output logic [N_CH-1:0]         req_ready,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic [$clog2(N_CH)-1:0] grant_id,
  output logic                    active,
  output logic                    err_timeout,
  output logic [FRAME_CNT_W-1:0]  frame_cnt
);

  localparam int unsigned IDX_W  = $clog2(N_CH);
  localparam int unsigned WCNT_W = $clog2(WAIT_CYC);

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  rr_next;
  logic [WCNT_W-1:0] wcnt;
  logic [IDX_W-1:0]  winner;
  logic              any_valid;
  logic              accept;
  logic [7:0]        ch_byte [N_CH];
  logic [7:0]        win_data;
`ifdef UART_ARB_TAG_EN
  logic [7:0]        data_hold;
  logic              phase;
`endif

  uart_rr_pick #(.N_CH(N_CH)) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) ch_byte[k] = req_data[8*k +: 8];
  end

  assign win_data  = ch_byte[winner];
  assign accept    = !reset && (state == IDLE) && !tx_busy && any_valid;
  assign req_ready = accept ? (N_CH'(1) << winner) : '0;
  assign rr_next   = (grant_id == IDX_W'(N_CH-1)) ? '0 : grant_id + IDX_W'(1);

  // Arbiter FSM with registered outputs; tx_start is high only while in LAUNCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wcnt        <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
      frame_cnt   <= '0;
`ifdef UART_ARB_TAG_EN
      data_hold   <= 8'h00;
      phase       <= 1'b0;
`endif
    end else begin
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            grant_id <= winner;
            tx_start <= 1'b1;
            active   <= 1'b1;
            state    <= LAUNCH;
`ifdef UART_ARB_TAG_EN
            data_hold <= win_data;
            tx_data   <= {TAG_PREFIX, 4'h0} | 8'(winner);
            phase     <= 1'b0;
`else
            tx_data  <= win_data;
`endif
          end
        end
        LAUNCH: begin
          wcnt  <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (wcnt == WCNT_W'(WAIT_CYC-2)) begin
            // counter would reach WAIT_CYC-1: give up on this byte
            err_timeout <= 1'b1;
            rr_ptr      <= rr_next;
            active      <= 1'b0;
            state       <= IDLE;
`ifdef UART_ARB_TAG_EN
            phase       <= 1'b0;
`endif
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
            if (!phase) begin
              // tag frame done: launch the held data byte directly
              phase    <= 1'b1;
              tx_data  <= data_hold;
              tx_start <= 1'b1;
              state    <= LAUNCH;
            end else begin
              phase     <= 1'b0;
              frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
              rr_ptr    <= rr_next;
              active    <= 1'b0;
              state     <= IDLE;
            end
`else
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            rr_ptr    <= rr_next;
            active    <= 1'b0;
            state     <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_CH=4, WAIT_CYC=16).
// A small transmitter model raises tx_busy the cycle after tx_start and holds
// it for 11 cycles; force_busy overrides it high, model_en disables it.
module tb_uart_tx_arbiter;

  localparam int unsigned N_CH     = 4;
  localparam int unsigned WAIT_CYC = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [31:0]  req_data;
  logic [3:0]   req_ready;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_busy;
  logic [1:0]   grant_id;
  logic         active;
  logic         err_timeout;
  logic [15:0]  frame_cnt;

  logic         force_busy;
  logic         model_en;
  int           busy_cnt = 0;

  int errors = 0;
  int checks = 0;
  int nstart;
  int nready;
  int nerr;
  logic found;

  uart_tx_arbiter #(.N_CH(N_CH), .WAIT_CYC(WAIT_CYC)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  // transmitter model: busy for 11 cycles starting the cycle after tx_start
  always @(posedge clk) begin
    if (model_en && tx_start) busy_cnt <= 11;
    else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (model_en && (busy_cnt != 0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(output logic f);
    f = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (tx_start === 1'b1) begin
        f = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 40; i++) begin
      if (active === 1'b0) break;
      tick;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 4'b0000;
    req_data   = 32'h0;
    force_busy = 1'b0;
    model_en   = 1'b1;
    repeat (3) tick;
    check("rst_ready",    32'(req_ready),   32'h0);
    check("rst_start",    32'(tx_start),    32'h0);
    check("rst_data",     32'(tx_data),     32'h0);
    check("rst_grant",    32'(grant_id),    32'h0);
    check("rst_active",   32'(active),      32'h0);
    check("rst_timeout",  32'(err_timeout), 32'h0);
    check("rst_framecnt", 32'(frame_cnt),   32'h0);
    reset = 1'b0;

`ifndef UART_ARB_TAG_EN
    // single request on channel 0
    tick;
    req_data[7:0] = 8'h55;
    req_valid     = 4'b0001;
    #1;
    check("t1_ready_same_cycle", 32'(req_ready), 32'h1);
    check("t1_no_start_yet",     32'(tx_start),  32'h0);
    tick;
    check("t1_start",    32'(tx_start), 32'h1);
    check("t1_data",     32'(tx_data),  32'h55);
    check("t1_grant",    32'(grant_id), 32'h0);
    check("t1_active",   32'(active),   32'h1);
    check("t1_ready_lo", 32'(req_ready), 32'h0);
    req_valid        = 4'b0100;
    req_data[23:16]  = 8'h66;
    nstart = 0;
    nready = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (tx_start)         nstart++;
      if (req_ready != '0)  nready++;
    end
    check("t1_busy_fell",     32'(tx_busy), 32'h0);
    check("t1_still_active",  32'(active),  32'h1);
    check("t1_no_restart",    32'(nstart),  32'h0);
    check("t1_ready_held_lo", 32'(nready),  32'h0);
    tick;
    check("t1_idle",     32'(active),    32'h0);
    check("t1_framecnt", 32'(frame_cnt), 32'h1);
    check("t1_rr_next",  32'(req_ready), 32'h4);
    req_valid = 4'b0000;

    // fairness from rr_ptr=0
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("rst2_framecnt", 32'(frame_cnt), 32'h0);
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start(found);
      check("rr_found", 32'(found),    32'h1);
      check("rr_grant", 32'(grant_id), 32'(k % 4));
      check("rr_data",  32'(tx_data),  32'(8'h10 + k % 4));
      tick;
      check("rr_pulse_width", 32'(tx_start), 32'h0);
    end
    req_valid = 4'b0000;
    wait_idle;
    check("rr_idle",     32'(active),    32'h0);
    check("rr_framecnt", 32'(frame_cnt), 32'h5);

    // timeout: transmitter never goes busy
    model_en       = 1'b0;
    req_data[15:8] = 8'h77;
    req_valid      = 4'b0010;
    wait_start(found);
    check("to_found", 32'(found),    32'h1);
    check("to_grant", 32'(grant_id), 32'h1);
    check("to_data",  32'(tx_data),  32'h77);
    req_valid = 4'b0000;
    nerr = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (err_timeout) nerr++;
    end
    check("to_not_early", 32'(nerr), 32'h0);
    tick;
    check("to_pulse",    32'(err_timeout), 32'h1);
    check("to_idle",     32'(active),      32'h0);
    check("to_framecnt", 32'(frame_cnt),   32'h5);
    tick;
    check("to_pulse_end", 32'(err_timeout), 32'h0);
    req_valid = 4'b1111;
    #1;
    check("to_rr_next", 32'(req_ready), 32'h4);

    // reset while in WAIT_DONE, transmitter stays busy afterwards
    model_en = 1'b1;
    tick;
    check("rd_grant", 32'(grant_id), 32'h2);
    check("rd_data",  32'(tx_data),  32'h12);
    req_valid = 4'b0010;
    repeat (3) tick;
    check("rd_in_frame", 32'(active), 32'h1);
    reset      = 1'b1;
    force_busy = 1'b1;
    tick;
    check("rd_active",   32'(active),    32'h0);
    check("rd_start",    32'(tx_start),  32'h0);
    check("rd_data0",    32'(tx_data),   32'h0);
    check("rd_grant0",   32'(grant_id),  32'h0);
    check("rd_framecnt", 32'(frame_cnt), 32'h0);
    check("rd_ready",    32'(req_ready), 32'h0);
    reset  = 1'b0;
    nready = 0;
    for (int i = 0; i < 14; i++) begin
      tick;
      if ((req_ready != '0) || active) nready++;
    end
    check("rd_no_grant_busy", 32'(nready), 32'h0);
    force_busy = 1'b0;
    #1;
    check("rd_ready_on_fall", 32'(req_ready), 32'h2);
    tick;
    check("rd_start_after", 32'(tx_start), 32'h1);
    check("rd_grant_after", 32'(grant_id), 32'h1);
    check("rd_data_after",  32'(tx_data),  32'h77);
    req_valid = 4'b0000;
    wait_idle;
    check("rd_framecnt_after", 32'(frame_cnt), 32'h1);
`else
    // tag + data pair from channel 2
    tick;
    req_data[23:16] = 8'h3C;
    req_valid       = 4'b0100;
    #1;
    check("tag_ready", 32'(req_ready), 32'h4);
    tick;
    check("tag_start", 32'(tx_start), 32'h1);
    check("tag_byte",  32'(tx_data),  32'hA2);
    check("tag_grant", 32'(grant_id), 32'h2);
    nready = 0;
    nstart = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (active === 1'b0) break;
      if (req_ready != '0) nready++;
      if (tx_start) begin
        nstart++;
        check("tag_data_byte", 32'(tx_data),   32'h3C);
        check("tag_cnt_mid",   32'(frame_cnt), 32'h0);
      end
    end
    req_valid = 4'b0000;
    check("tag_idle",      32'(active),    32'h0);
    check("tag_one_ready", 32'(nready),    32'h0);
    check("tag_two_start", 32'(nstart),    32'h1);
    check("tag_framecnt",  32'(frame_cnt), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
